cic_decimator: RTL and testbench

- Parametrised multi-channel CIC decimation filter for PDM microphone bitstreams.
- Successor to the fixed 19-bit, externally strobed CIC. Order, decimation ratio, differential delay and channel count are set by parameters.
- Generates its own decimation strobe and presents results on a valid/ready output with overrun detection.
- Sits between the PDM front end and the beamformer delay/sum path.

---
 rtl/cic_pkg.sv | 12 +
 rtl/cic_comb_stage.sv | 40 ++++
 rtl/cic_decimator.sv | 113 +++++++++++
 tb/tb_cic_decimator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and width helper for the multi-channel CIC decimator.
package cic_pkg;

  localparam int MAX_ORDER      = 6;
  localparam int MAX_DIFF_DELAY = 2;

  // Full-precision result width: one sign bit plus the CIC bit growth.
  function automatic int cic_out_w(input int order, input int dec, input int m);
    return 1 + order * $clog2(dec * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb stage of one channel: a frame-rate delay line and a registered subtract.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 10,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  if (M < 1 || M > MAX_DIFF_DELAY) begin : g_bad_m
    $error("cic_comb_stage: differential delay out of range");
  end

  logic [W-1:0] r_dly [M];
  logic [W-1:0] r_y;

  // The delay line only moves when a decimated frame passes this stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_y <= '0;
      for (int k = 0; k < M; k++) r_dly[k] <= '0;
    end else if (i_clr) begin
      r_y <= '0;
      for (int k = 0; k < M; k++) r_dly[k] <= '0;
    end else if (i_en) begin
      r_y      <= i_x - r_dly[M-1];
      r_dly[0] <= i_x;
      for (int k = 1; k < M; k++) r_dly[k] <= r_dly[k-1];
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/cic_decimator.sv
// Multi-channel CIC decimator for PDM lanes: pipelined integrators, self-timed
// decimation strobe, comb pipeline and a valid/ready result port with overrun flag.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int ORDER      = 3,
  parameter int DEC        = 64,
  parameter int DIFF_DELAY = 1,
  parameter int OUT_W      = cic_out_w(ORDER, DEC, DIFF_DELAY)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic [CHANNELS-1:0]       pdm_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      overrun
);

  localparam int               CNT_W     = $clog2(DEC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEC - 1);
  localparam logic [OUT_W-1:0] PLUS_ONE  = OUT_W'(1);
  localparam logic [OUT_W-1:0] MINUS_ONE = '1;

  if (OUT_W != cic_out_w(ORDER, DEC, DIFF_DELAY)) begin : g_bad_w
    $error("cic_decimator: OUT_W is derived and must not be overridden");
  end
  if (ORDER < 1 || ORDER > MAX_ORDER || DEC < 2 || CHANNELS < 1) begin : g_bad_cfg
    $error("cic_decimator: illegal ORDER, DEC or CHANNELS");
  end

  logic [CNT_W-1:0] r_cnt;
  logic [ORDER-1:0] r_en;
  logic [OUT_W-1:0] r_integ [CHANNELS][ORDER];
  logic [OUT_W-1:0] w_comb  [CHANNELS][ORDER+1];
  logic             r_out_valid;
  logic             r_overrun;

  // r_en[0] is the capture strobe; r_en[j] advances comb stage j one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_en  <= '0;
    end else if (clr) begin
      r_cnt <= '0;
      r_en  <= '0;
    end else begin
      r_en[0] <= in_valid && (r_cnt == CNT_LAST);
      for (int j = 1; j < ORDER; j++) r_en[j] <= r_en[j-1];
      if (in_valid) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Each integrator adds the registered value of the previous one; wrap is intended.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < ORDER; k++) r_integ[c][k] <= '0;
    end else if (clr) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < ORDER; k++) r_integ[c][k] <= '0;
    end else if (in_valid) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_integ[c][0] <= r_integ[c][0] + (pdm_in[c] ? PLUS_ONE : MINUS_ONE);
        for (int k = 1; k < ORDER; k++) r_integ[c][k] <= r_integ[c][k] + r_integ[c][k-1];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_comb[c][0] = r_integ[c][ORDER-1];
    for (genvar j = 0; j < ORDER; j++) begin : g_st
      cic_comb_stage #(
        .W (OUT_W),
        .M (DIFF_DELAY)
      ) u_comb (
        .clk   (clk),
        .rst   (rst),
        .i_clr (clr),
        .i_en  (r_en[j]),
        .i_x   (w_comb[c][j]),
        .o_y   (w_comb[c][j+1])
      );
    end
    assign out_data[c*OUT_W +: OUT_W] = w_comb[c][ORDER];
  end

  // Handshake: a result is transferred on a cycle with out_valid && out_ready; while
  // out_valid && !out_ready the data is held, except that a newly landed frame
  // replaces it (setting sticky overrun). A frame landing in the accept cycle keeps
  // out_valid high with the new data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clr) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_en[ORDER-1]) begin
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) r_overrun <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator (2 lanes, order 3, R=8, M=1): directed and random PDM
// streams against an arithmetic CIC model and a handshake scoreboard.
module tb_cic_decimator;

  localparam int CH  = 2;
  localparam int ORD = 3;
  localparam int DEC = 8;
  localparam int M   = 1;
  localparam int W   = 10;
  localparam int DW  = CH * W;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic [CH-1:0] pdm_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          overrun;

  cic_decimator #(
    .CHANNELS   (CH),
    .ORDER      (ORD),
    .DEC        (DEC),
    .DIFF_DELAY (M)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .pdm_in    (pdm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            checks;
  int            errors;
  int            cyc_n;
  int            nacc;
  logic [CH-1:0] hist[$];
  logic [DW-1:0] exp_q[$];
  int            arr_q[$];
  logic          exp_v;
  logic          exp_ovr;
  logic [DW-1:0] exp_d;
  logic [DW-1:0] obs_cur;
  logic [DW-1:0] obs_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame f from the sample history: ORDER running sums (the last integrator lags
  // ORDER-1 samples behind the input), sampled every DEC inputs, then ORDER
  // differences of lag M over frames; truncated to W bits.
  function automatic logic [DW-1:0] model_frame(input int f);
    logic [DW-1:0] res;
    longint        a[];
    longint        v[];
    longint        t;
    int            n;
    int            idx;
    res = '0;
    n = (f + 1) * DEC;
    for (int ch = 0; ch < CH; ch++) begin
      a = new[n];
      for (int i = 0; i < n; i++) a[i] = hist[i][ch] ? 64'sd1 : -64'sd1;
      for (int s = 0; s < ORD; s++)
        for (int i = 1; i < n; i++) a[i] = a[i] + a[i-1];
      v = new[f + 1];
      for (int g = 0; g <= f; g++) begin
        idx = g * DEC + DEC - 1 - (ORD - 1);
        v[g] = (idx >= 0) ? a[idx] : 64'sd0;
      end
      for (int s = 0; s < ORD; s++)
        for (int g = f; g >= 0; g--) v[g] = v[g] - ((g >= M) ? v[g-M] : 64'sd0);
      t = v[f];
      res[ch*W +: W] = t[W-1:0];
    end
    return res;
  endfunction

  task automatic clear_model();
    hist.delete();
    exp_q.delete();
    arr_q.delete();
    nacc    = 0;
    exp_v   = 1'b0;
    exp_ovr = 1'b0;
    exp_d   = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cyc(input logic v, input logic [CH-1:0] b, input logic r, input logic c);
    @(negedge clk);
    cyc_n++;
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("overrun", 64'(overrun), 64'(exp_ovr));
    if (exp_v) chk("out_data", 64'(out_data), 64'(exp_d));
    obs_cur   = out_data;
    in_valid  = v;
    pdm_in    = b;
    out_ready = r;
    clr       = c;
    if (c) begin
      clear_model();
    end else begin
      if (v) begin
        hist.push_back(b);
        nacc++;
        if (nacc % DEC == 0) begin
          exp_q.push_back(model_frame(nacc / DEC - 1));
          arr_q.push_back(cyc_n + ORD + 1);
        end
      end
      if (exp_v && r) obs_acc = obs_cur;
      if (arr_q.size() > 0 && arr_q[0] == cyc_n + 1) begin
        exp_ovr = exp_ovr | (exp_v & ~r);
        exp_v   = 1'b1;
        exp_d   = exp_q.pop_front();
        void'(arr_q.pop_front());
      end else if (r) begin
        exp_v = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    cyc_n++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_data", 64'(out_data), 64'd0);
    chk("async_rst_overrun", 64'(overrun), 64'd0);
    clear_model();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [CH-1:0] b;
    logic          v;
    logic          r;
    int            k;
    checks = 0;
    errors = 0;
    cyc_n  = 0;
    obs_acc = '0;
    obs_cur = '0;
    rst = 1'b0;
    clr = 1'b0;
    in_valid  = 1'b0;
    pdm_in    = '0;
    out_ready = 1'b1;
    clear_model();

    #12;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // DC high: +512 aliases to 10'h200 in the 10-bit result
    for (int i = 0; i < 6 * DEC; i++) cyc(1'b1, 2'b11, 1'b1, 1'b0);
    drain(ORD + 3);
    chk("dc_high_ch0", 64'(obs_acc[W-1:0]), 64'h200);
    chk("dc_high_ch1", 64'(obs_acc[2*W-1:W]), 64'h200);

    // clear with in_valid high: the sample must be dropped
    cyc(1'b1, 2'b11, 1'b1, 1'b1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    chk("clr_data", 64'(obs_cur), 64'd0);

    // ch0 high, ch1 low: +512 and -512 share the pattern 10'h200
    for (int i = 0; i < 6 * DEC; i++) cyc(1'b1, 2'b01, 1'b1, 1'b0);
    drain(ORD + 3);
    chk("mixed_ch0", 64'(obs_acc[W-1:0]), 64'h200);
    chk("mixed_ch1", 64'(obs_acc[2*W-1:W]), 64'h200);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);

    // ch0 alternating -> 0, ch1 25% duty -> -256 (10'h300); also checks lane packing
    for (int i = 0; i < 6 * DEC; i++) begin
      b[0] = (i % 2 == 0);
      b[1] = (i % 4 == 0);
      cyc(1'b1, b, 1'b1, 1'b0);
    end
    drain(ORD + 3);
    chk("alt_ch0", 64'(obs_acc[W-1:0]), 64'h000);
    chk("duty25_ch1", 64'(obs_acc[2*W-1:W]), 64'h300);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);

    // in_valid every third cycle: ch0 high, ch1 alternating per accepted sample
    for (int i = 0; i < 6 * DEC * 3; i++) begin
      k = i / 3;
      b[0] = 1'b1;
      b[1] = (k % 2 == 0);
      cyc((i % 3) == 0, b, 1'b1, 1'b0);
    end
    drain(ORD + 3);
    chk("gap_ch0", 64'(obs_acc[W-1:0]), 64'h200);
    chk("gap_ch1", 64'(obs_acc[2*W-1:W]), 64'h000);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);

    // random bits with random gaps
    for (int i = 0; i < 12 * DEC; i++) begin
      b = CH'($urandom_range(0, 3));
      v = ($urandom_range(0, 3) != 0);
      cyc(v, b, 1'b1, 1'b0);
    end
    drain(ORD + 3);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);

    // backpressure across two frames: second frame (0+392 per lane) overwrites the first
    for (int i = 0; i < 2 * DEC; i++) cyc(1'b1, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < ORD + 2; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    chk("bp_valid_held", 64'(out_valid), 64'd1);
    chk("bp_overrun_set", 64'(overrun), 64'd1);
    chk("bp_second_frame", 64'(out_data), 64'({10'd392, 10'd392}));
    drain(4);
    chk("bp_valid_dropped", 64'(out_valid), 64'd0);
    chk("bp_overrun_sticky", 64'(overrun), 64'd1);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0);
    chk("clr_overrun", 64'(overrun), 64'd0);

    // reset after five samples; the next frame must match a cold start (56 per lane)
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b11, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < DEC; i++) cyc(1'b1, 2'b11, 1'b1, 1'b0);
    drain(ORD + 2);
    chk("post_reset_frame0", 64'(obs_acc), 64'({10'd56, 10'd56}));

    // random input, random gaps and random backpressure
    cyc(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 16 * DEC; i++) begin
      b = CH'($urandom_range(0, 3));
      v = ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(v, b, r, 1'b0);
    end
    drain(ORD + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
